imem_port_arbiter: RTL

Two-requester arbiter sharing the single-port instruction SRAM of the SystemControl subsystem between the core (port 0) and the debug-module system-bus access (port 1, used for program upload and readMem polling). Presents an OBI-style req/gnt/rvalid slave interface per requester and a 1-cycle-latency SRAM master interface. Provides round-robin fairness, a debug lock for uninterrupted burst uploads, and an error response for out-of-window addresses.

---
 rtl/imem_port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port instruction SRAM between the core (port 0)
// and the debug SBA (port 1) with round-robin fairness, a debug lock and window errors.
module imem_port_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0100_0000,
    parameter int                    LOCK_MAX   = 255,
    localparam int                   BW         = DATA_WIDTH / 8,
    localparam int                   WA         = $clog2(MEM_WORDS)
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_we,
    input  logic [BW-1:0]         p0_be,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_we,
    input  logic [BW-1:0]         p1_be,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic                  sram_req,
    output logic                  sram_we,
    output logic [WA-1:0]         sram_addr,
    output logic [BW-1:0]         sram_be,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);
    localparam int                  CW   = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0]       CMAX = CW'(LOCK_MAX);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);

    typedef enum logic {ST_RR, ST_LOCK} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_last;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_rsp_vld, r_rsp_own, r_rsp_err, r_rsp_rd;
    logic                  w_g0, w_g1, w_acc, w_at_max, w_yield, w_we, w_in_win;
    logic [ADDR_WIDTH-1:0] w_addr, w_off;
    logic [BW-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_wdata;

    // r_last=1 means port 1 was granted last, so port 0 wins the next tie
    assign w_at_max = r_cnt == CMAX;
    assign w_yield  = (r_state == ST_LOCK) && w_at_max && p0_req;
    assign w_g0     = reset && (r_state == ST_RR) && p0_req && (!p1_req || r_last);
    assign w_g1     = reset && p1_req && ((r_state == ST_LOCK) ? !w_yield : (!p0_req || !r_last));
    assign w_acc    = w_g0 || w_g1;
    assign p0_gnt   = w_g0;
    assign p1_gnt   = w_g1;

    assign w_addr   = w_g1 ? p1_addr  : p0_addr;
    assign w_we     = w_g1 ? p1_we    : p0_we;
    assign w_be     = w_g1 ? p1_be    : p0_be;
    assign w_wdata  = w_g1 ? p1_wdata : p0_wdata;
    assign w_off    = w_addr - BASE_ADDR;
    assign w_in_win = (w_addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);

    assign sram_req   = w_acc && w_in_win;
    assign sram_we    = sram_req && w_we;
    assign sram_addr  = sram_req ? w_off[WA+1:2] : '0;
    assign sram_be    = sram_req ? w_be : '0;
    assign sram_wdata = sram_req ? w_wdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_RR) begin
            if (w_g1 && p1_lock) begin
                w_state_nxt = ST_LOCK;
                w_cnt_nxt   = CW'(1);
            end
        end else begin
            if (w_g1 && !w_at_max) w_cnt_nxt = r_cnt + 1'b1;
            // hand back on lock release, or once the burst budget is spent while the core waits
            if (!p1_lock || w_yield || (w_g1 && p0_req && w_cnt_nxt == CMAX)) begin
                w_state_nxt = ST_RR;
                w_cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RR;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_own <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_rd  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_acc) r_last <= w_g1;
            r_rsp_vld <= w_acc;
            r_rsp_own <= w_g1;
            r_rsp_err <= w_acc && !w_in_win;
            r_rsp_rd  <= sram_req && !w_we;
        end
    end

    assign p0_rvalid = r_rsp_vld && !r_rsp_own;
    assign p1_rvalid = r_rsp_vld && r_rsp_own;
    assign p0_err    = p0_rvalid && r_rsp_err;
    assign p1_err    = p1_rvalid && r_rsp_err;
    assign p0_rdata  = (p0_rvalid && r_rsp_rd) ? sram_rdata : '0;
    assign p1_rdata  = (p1_rvalid && r_rsp_rd) ? sram_rdata : '0;
endmodule
